// File: rtl/covox_pkg.sv
// rtl/covox_pkg.sv - shared widths, depths and default tuning constants for the covox sigma-delta DAC
package covox_pkg;

  localparam int DATA_W           = 8;
  localparam int MIX_W            = 9;
  localparam int FIFO_DEPTH       = 4;
  localparam int FIFO_AW          = 2;
  localparam int TIMER_W          = 12;

  localparam int DIV_DEFAULT      = 80;
  localparam int BEEP_LVL_DEFAULT = 64;
  localparam int TAPE_LVL_DEFAULT = 16;

  typedef logic [DATA_W-1:0] sample_t;
  typedef logic [MIX_W-1:0]  mix_t;

  // Mid-scale sample so the output idles at half density after reset.
  localparam sample_t SAMPLE_IDLE = 8'h80;

  // Unsigned mix of the DAC sample with the beeper and tape-out levels.
  // The level parameters are constrained so the sum always fits in MIX_W.
  function automatic mix_t mix_sum(input sample_t s, input logic b, input logic t,
                                   input mix_t b_lvl, input mix_t t_lvl);
    mix_sum = {1'b0, s} + (b ? b_lvl : '0) + (t ? t_lvl : '0);
  endfunction

endpackage

// File: rtl/covox_fifo.sv
// rtl/covox_fifo.sv - 4-entry sample FIFO; pop on empty is ignored, push on full only lands if a pop frees a slot
module covox_fifo
  import covox_pkg::*;
(
  input  logic         cpu_clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  sample_t      din,
  output sample_t      dout,
  output logic [2:0]   level,
  output logic         full,
  output logic         empty
);

  sample_t            mem [FIFO_DEPTH];
  logic [FIFO_AW:0]   wptr;
  logic [FIFO_AW:0]   rptr;
  logic               do_push;
  logic               do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level   = wptr - rptr;
  assign full    = (level == 3'(FIFO_DEPTH));
  assign empty   = (level == 3'd0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rptr[FIFO_AW-1:0]];

  // Pointer update; reset discards any queued samples.
  always_ff @(posedge cpu_clock or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage needs no reset: entries are only visible between push and pop.
  always_ff @(posedge cpu_clock) begin
    if (do_push) mem[wptr[FIFO_AW-1:0]] <= din;
  end

endmodule

// File: rtl/covox_sd_dac.sv
// rtl/covox_sd_dac.sv - covox port capture, optional paced FIFO playback (COVOX_FIFO_EN), mixer and 1-bit sigma-delta modulator
module covox_sd_dac
  import covox_pkg::*;
#(
  parameter int DIV      = DIV_DEFAULT,
  parameter int BEEP_LVL = BEEP_LVL_DEFAULT,
  parameter int TAPE_LVL = TAPE_LVL_DEFAULT
)(
  input  logic         cpu_clock,
  input  logic         reset,
  input  logic         covox,
  input  logic [7:0]   d,
  input  logic         beeper,
  input  logic         tapeout,
  output logic         audio_pdm,
  output logic [7:0]   sample_q,
  output logic         overrun,
  output logic [2:0]   fifo_level
);

  localparam mix_t BEEP_MIX = MIX_W'(BEEP_LVL);
  localparam mix_t TAPE_MIX = MIX_W'(TAPE_LVL);

  logic     s1;
  logic     s2;
  sample_t  d1;
  sample_t  d2;
  sample_t  hold;
  sample_t  hold_d;
  logic     commit;
  mix_t     mix;
  logic [9:0] acc;
  logic [9:0] acc_sum;

  // Strobe and data share one two-stage synchroniser so they stay aligned.
  always_ff @(posedge cpu_clock or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      d1 <= '0;
      d2 <= '0;
    end else begin
      s1 <= covox;
      s2 <= s1;
      d1 <= d;
      d2 <= d1;
    end
  end

  // Hold tracks the bus while the synchronised strobe is high; the value
  // committed on the falling edge of the strobe is the hold input that cycle.
  assign hold_d = s2 ? d2 : hold;
  assign commit = s2 & ~s1;

  // Hold register: last bus value seen under the strobe.
  always_ff @(posedge cpu_clock or negedge reset) begin
    if (!reset) hold <= '0;
    else        hold <= hold_d;
  end

`ifdef COVOX_FIFO_EN

  logic [TIMER_W-1:0] timer;
  logic               tick;
  sample_t            fifo_dout;
  logic               fifo_full;
  logic               fifo_empty;

  assign tick = (timer == TIMER_W'(DIV - 1));

  // Free-running sample-rate timer, one tick every DIV cycles.
  always_ff @(posedge cpu_clock or negedge reset) begin
    if (!reset)    timer <= '0;
    else if (tick) timer <= '0;
    else           timer <= timer + 1'b1;
  end

  covox_fifo u_fifo (
    .cpu_clock (cpu_clock),
    .reset     (reset),
    .push      (commit),
    .pop       (tick),
    .din       (hold_d),
    .dout      (fifo_dout),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Paced playback: a tick moves the FIFO head to the DAC, an empty FIFO keeps the last sample.
  always_ff @(posedge cpu_clock or negedge reset) begin
    if (!reset)                   sample_q <= SAMPLE_IDLE;
    else if (tick && !fifo_empty) sample_q <= fifo_dout;
  end

  // Sticky overflow: a write arrived with the FIFO full and no pop to make room.
  always_ff @(posedge cpu_clock or negedge reset) begin
    if (!reset)                             overrun <= 1'b0;
    else if (commit && fifo_full && !tick)  overrun <= 1'b1;
  end

`else

  // Direct mode: each committed write goes straight to the DAC.
  always_ff @(posedge cpu_clock or negedge reset) begin
    if (!reset)      sample_q <= SAMPLE_IDLE;
    else if (commit) sample_q <= hold_d;
  end

  assign overrun    = 1'b0;
  assign fifo_level = 3'd0;

`endif

  // First-order sigma-delta: the carry out of the 9-bit accumulator is the PDM bit,
  // kept in acc[9] so the output is registered without a separate flop.
  assign mix       = mix_sum(sample_q, beeper, tapeout, BEEP_MIX, TAPE_MIX);
  assign acc_sum   = {1'b0, acc[8:0]} + {1'b0, mix};
  assign audio_pdm = acc[9];

  // Modulator accumulator.
  always_ff @(posedge cpu_clock or negedge reset) begin
    if (!reset) acc <= '0;
    else        acc <= acc_sum;
  end

endmodule

// File: tb/tb_covox_sd_dac.sv
// tb/tb_covox_sd_dac.sv - randomized and directed self-checking bench for covox_sd_dac (COVOX_FIFO_EN selects the FIFO build)
module tb_covox_sd_dac;

  localparam int DIV  = 80;
  localparam int BEEP = 64;
  localparam int TAPE = 16;

  logic       cpu_clock = 1'b0;
  logic       reset     = 1'b0;
  logic       covox     = 1'b0;
  logic [7:0] d         = 8'h00;
  logic       beeper    = 1'b0;
  logic       tapeout   = 1'b0;
  logic       audio_pdm;
  logic [7:0] sample_q;
  logic       overrun;
  logic [2:0] fifo_level;

  int n_checks = 0;
  int n_fail   = 0;

  covox_sd_dac #(.DIV(DIV), .BEEP_LVL(BEEP), .TAPE_LVL(TAPE)) dut (
    .cpu_clock  (cpu_clock),
    .reset      (reset),
    .covox      (covox),
    .d          (d),
    .beeper     (beeper),
    .tapeout    (tapeout),
    .audio_pdm  (audio_pdm),
    .sample_q   (sample_q),
    .overrun    (overrun),
    .fifo_level (fifo_level)
  );

  always #5 cpu_clock = ~cpu_clock;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Behavioural reference: writes become pending events, the FIFO is a queue,
  // the modulator is modular arithmetic on an integer accumulator.
  int m_sample = 128;
  int m_pdm    = 0;
  int m_over   = 0;
  int m_acc    = 0;
  int m_tcnt   = 0;
  int edge_n   = 0;
  int fifo_q[$];
  bit prev_cov = 0;
  int prev_d   = 0;
  bit pend     = 0;
  int pend_val = 0;

  always @(posedge cpu_clock) begin : model
    bit commit_now;
    int cval;
    int mix;
    int sum;
    if (!reset) begin
      m_sample = 128; m_pdm = 0; m_over = 0; m_acc = 0; m_tcnt = 0; edge_n = 0;
      fifo_q.delete(); prev_cov = 0; prev_d = 0; pend = 0; pend_val = 0;
    end else begin
      commit_now = pend;
      cval       = pend_val;
      pend       = 0;
      mix   = m_sample + (beeper ? BEEP : 0) + (tapeout ? TAPE : 0);
      sum   = (m_acc % 512) + mix;
      m_pdm = (sum >= 512) ? 1 : 0;
      m_acc = sum;
      edge_n++;
`ifdef COVOX_FIFO_EN
      if (m_tcnt == DIV - 1 && fifo_q.size() > 0) m_sample = fifo_q.pop_front();
      if (commit_now) begin
        if (fifo_q.size() < 4) fifo_q.push_back(cval);
        else                   m_over = 1;
      end
      m_tcnt = (m_tcnt + 1) % DIV;
`else
      if (commit_now) m_sample = cval;
`endif
      // A strobe seen high then low schedules one commit of the last data seen high.
      if (prev_cov && !covox) begin
        pend     = 1;
        pend_val = prev_d;
      end
      prev_cov = covox;
      prev_d   = d;
    end
    #1;
    check("sample_q", sample_q, m_sample);
    check("audio_pdm", audio_pdm, m_pdm);
    check("overrun", overrun, m_over);
`ifdef COVOX_FIFO_EN
    check("fifo_level", fifo_level, fifo_q.size());
`else
    check("fifo_level", fifo_level, 0);
`endif
  end

  task automatic do_reset();
    @(negedge cpu_clock);
    reset = 1'b0; covox = 1'b0; beeper = 1'b0; tapeout = 1'b0;
    repeat (2) @(negedge cpu_clock);
    reset = 1'b1;
  endtask

  // Strobe high for len cycles; the bus only carries v on the last high cycle.
  task automatic write_len(input logic [7:0] v, input int len);
    for (int i = 0; i < len; i++) begin
      @(negedge cpu_clock);
      covox = 1'b1;
      d     = (i == len - 1) ? v : 8'($urandom);
    end
    @(negedge cpu_clock);
    covox = 1'b0;
    d     = 8'($urandom);
  endtask

  task automatic wait_edge(input int n);
    int guard = 0;
    while (edge_n < n && guard < 20000) begin
      @(posedge cpu_clock);
      #1;
      guard++;
    end
    if (edge_n < n) check("wait_edge_timeout", edge_n, n);
  endtask

  task automatic count_pdm(output int cnt);
    cnt = 0;
    for (int i = 0; i < 512; i++) begin
      @(posedge cpu_clock);
      #1;
      cnt += int'(audio_pdm);
    end
  endtask

  initial begin : watchdog
    #3000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : stim
    int cnt;
    int seen;

    // Reset values.
    do_reset();
    @(posedge cpu_clock); #1;
    check("reset_sample_q", sample_q, 8'h80);
    check("reset_audio_pdm", audio_pdm, 0);
    check("reset_overrun", overrun, 0);
    check("reset_fifo_level", fifo_level, 0);

    // Three-cycle strobe: result lands on the second edge after covox is sampled low.
    @(negedge cpu_clock); covox = 1'b1; d = 8'h3C;
    repeat (2) @(negedge cpu_clock);
    @(negedge cpu_clock); covox = 1'b0; d = 8'hFF;
    @(posedge cpu_clock); #1;
`ifdef COVOX_FIFO_EN
    check("lat_first_edge_level", fifo_level, 0);
    @(posedge cpu_clock); #1;
    check("lat_commit_level", fifo_level, 1);
    repeat (5) @(posedge cpu_clock); #1;
    check("lat_single_push", fifo_level, 1);
`else
    check("lat_first_edge_sample", sample_q, 8'h80);
    @(posedge cpu_clock); #1;
    check("lat_commit_sample", sample_q, 8'h3C);
    repeat (5) @(posedge cpu_clock); #1;
    check("lat_single_update", sample_q, 8'h3C);
`endif

    // Density: mid-scale sample plus beeper gives 192/512.
    do_reset();
    beeper = 1'b1;
    count_pdm(cnt);
    n_checks++;
    if (cnt < 191 || cnt > 193) begin
      n_fail++;
      $display("FAIL pdm_count_mix192: got %0d ones in 512 cycles, expected 192 +/- 1", cnt);
    end
    beeper = 1'b0;
    write_len(8'h00, 1);
    repeat (100) @(posedge cpu_clock);
    #1;
    check("zero_sample", sample_q, 0);
    count_pdm(cnt);
    check("pdm_count_zero", cnt, 0);

    // Strobe held through reset and dropped at release: no commit.
    @(negedge cpu_clock); reset = 1'b0; covox = 1'b1; d = 8'h55;
    repeat (2) @(negedge cpu_clock);
    reset = 1'b1; covox = 1'b0;
    repeat (10) @(posedge cpu_clock); #1;
    check("rel_drop_sample", sample_q, 8'h80);
    check("rel_drop_level", fifo_level, 0);

    // Strobe held through reset and kept after release: one commit.
    @(negedge cpu_clock); reset = 1'b0; covox = 1'b1; d = 8'h66;
    repeat (2) @(negedge cpu_clock);
    reset = 1'b1;
    repeat (3) @(negedge cpu_clock);
    covox = 1'b0;
    repeat (5) @(posedge cpu_clock); #1;
`ifdef COVOX_FIFO_EN
    check("rel_hold_level", fifo_level, 1);
`else
    check("rel_hold_sample", sample_q, 8'h66);
`endif

`ifdef COVOX_FIFO_EN
    // Three back-to-back writes played out on successive ticks.
    do_reset();
    write_len(8'h10, 1); write_len(8'h20, 1); write_len(8'h30, 1);
    wait_edge(70);  check("pace_level3", fifo_level, 3);
    wait_edge(79);  check("pace_pre_tick", sample_q, 8'h80);
    wait_edge(80);  check("pace_tick1", sample_q, 8'h10);
    wait_edge(159); check("pace_pre_tick2", sample_q, 8'h10);
    wait_edge(160); check("pace_tick2", sample_q, 8'h20);
    wait_edge(240); check("pace_tick3", sample_q, 8'h30);
    check("pace_level0", fifo_level, 0);
    wait_edge(400); check("pace_hold", sample_q, 8'h30);

    // Five writes between ticks: fifth dropped, overrun set.
    do_reset();
    for (int i = 1; i <= 5; i++) write_len(8'(8'hA0 + i), 1);
    wait_edge(20);
    check("ovf_level", fifo_level, 4);
    check("ovf_flag", overrun, 1);
    seen = 0;
    while (edge_n < 420) begin
      @(posedge cpu_clock); #1;
      if (sample_q == 8'hA5) seen++;
    end
    check("ovf_fifth_never_played", seen, 0);
    check("ovf_last_played", sample_q, 8'hA4);

    // Full FIFO with a commit landing on the tick edge.
    do_reset();
    for (int i = 1; i <= 4; i++) write_len(8'(8'hB0 + i), 1);
    wait_edge(77);
    @(negedge cpu_clock); covox = 1'b1; d = 8'hC7;
    @(negedge cpu_clock); covox = 1'b0; d = 8'h00;
    wait_edge(79);  check("tickpush_pre_level", fifo_level, 4);
    wait_edge(80);
    check("tickpush_level", fifo_level, 4);
    check("tickpush_overrun", overrun, 0);
    check("tickpush_tick1", sample_q, 8'hB1);
    wait_edge(320); check("tickpush_tick4", sample_q, 8'hB4);
    wait_edge(400); check("tickpush_new_played", sample_q, 8'hC7);
`endif

    // Reset in mid-operation clears everything at once; nothing stale afterwards.
    do_reset();
    beeper = 1'b1;
    write_len(8'h11, 1); write_len(8'h22, 1); write_len(8'h33, 1);
    wait_edge(20);
`ifdef COVOX_FIFO_EN
    check("midrst_level3", fifo_level, 3);
`else
    check("midrst_sample_before", sample_q, 8'h33);
`endif
    @(negedge cpu_clock);
    #2 reset = 1'b0;
    #1;
    check("midrst_sample_q", sample_q, 8'h80);
    check("midrst_audio_pdm", audio_pdm, 0);
    check("midrst_overrun", overrun, 0);
    check("midrst_level", fifo_level, 0);
    @(negedge cpu_clock);
    beeper = 1'b0;
    reset  = 1'b1;
    wait_edge(200);
    check("midrst_no_stale", sample_q, 8'h80);
    check("midrst_level_after", fifo_level, 0);

    // Randomized traffic; the model process checks every cycle.
    do_reset();
    for (int it = 0; it < 300; it++) begin
      int gap;
      beeper  = 1'($urandom);
      tapeout = 1'($urandom);
      write_len(8'($urandom), int'($urandom_range(1, 4)));
`ifdef COVOX_FIFO_EN
      gap = int'($urandom_range(0, 40));
`else
      gap = int'($urandom_range(0, 6));
`endif
      for (int g = 0; g < gap; g++) begin
        @(negedge cpu_clock);
        if ($urandom_range(0, 7) == 0) beeper  = ~beeper;
        if ($urandom_range(0, 7) == 0) tapeout = ~tapeout;
      end
      if (it == 150) begin
        @(negedge cpu_clock);
        covox = 1'b1;
        #3 reset = 1'b0;
        @(negedge cpu_clock);
        reset = 1'b1;
        covox = 1'b0;
      end
    end
    repeat (20) @(posedge cpu_clock);
    #2;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
